fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the tau processor. Owns the program counter (a `counter_loadable` instance) and sequences it: boots to a reset vector, fetches one instruction per handshake from instruction memory, presents it to decode, and advances or redirects the PC on branches. It sits between instruction memory and the decode stage and is the only writer of the PC.

## Interface
- `ADDR_WIDTH`, 8: PC and memory address width.
- `DATA_WIDTH`, 16: instruction width.
- `RESET_VECTOR`, 0: first fetch address after boot.

- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `run` in 1: start from IDLE, or resume from HALTED.
- `halt_req` in 1: request halt at next instruction boundary; a one-cycle pulse is enough.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_WIDTH: fetch address, equal to the current PC.
- `imem_ack` in 1: memory accepted the request and `imem_rdata` is valid this cycle.
- `imem_rdata` in DATA_WIDTH: fetched instruction.
- `instr_valid` out 1: `instr` is valid for decode.
- `instr` out DATA_WIDTH: registered instruction.
- `instr_pc` out ADDR_WIDTH: PC of `instr`.
- `instr_ready` in 1: decode consumes `instr` this cycle.
- `branch_valid` in 1: redirect; qualified only with `instr_valid && instr_ready`.
- `branch_target` in ADDR_WIDTH: redirect address.
- `halted` out 1: high in HALTED.
- `pc` out ADDR_WIDTH: current PC.

## Operation
- States:
  - IDLE: reset state; `run` → BOOT.
  - BOOT: single cycle; loads `RESET_VECTOR` into the PC → FETCH.
  - FETCH:
    - `imem_req`=1, `imem_addr`=PC.
    - Holds until `imem_ack`; `imem_addr` must stay stable meanwhile.
    - On ack, registers `imem_rdata` into `instr` and the PC into `instr_pc` → ISSUE.
  - ISSUE:
    - `instr_valid`=1; `instr` and `instr_pc` are held until `instr_ready`.
    - On `instr_ready` with `branch_valid`: PC ← `branch_target`.
    - On `instr_ready` without `branch_valid`: PC ← PC+1.
    - After `instr_ready`, next state is HALTED if `halt_pending`, otherwise FETCH.
  - HALTED: `halted`=1; `run` → FETCH at the current PC. There is no re-boot.
- `halt_pending` flag:
  - Set by `halt_req` in FETCH or ISSUE, including the same cycle as the ISSUE handshake.
  - Cleared on entry to HALTED.
  - `halt_req` in IDLE or HALTED is ignored.
- `run` outside IDLE/HALTED is ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH: 2^ADDR_WIDTH−1 + 1 → 0 with no flag.
- `branch_valid` without the ISSUE handshake is ignored.
- Counter control (to `u_pc`):
  - `enable`=1 constant; `count_down`=0 constant.
  - `count_up` = ISSUE ∧ `instr_ready` ∧ ¬`branch_valid`.
  - `load` = BOOT ∨ (ISSUE ∧ `instr_ready` ∧ `branch_valid`).
  - `load_value` = BOOT ? `RESET_VECTOR` : `branch_target`.
  - `count_up` and `load` are never high together; this is asserted in simulation, because the counter gives `count_up` priority.
- Reset in any state, including mid-fetch or mid-issue: the next cycle is IDLE, PC=0, `halt_pending`=0, and the pending fetch is abandoned. Memory must tolerate the dropped request.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `halted`=0, `pc`=0.
- `imem_req`, `instr_valid` and `halted` decode from registered state only, never combinationally from inputs.
- `run` high in IDLE at cycle 0:
  - Cycle 1: BOOT.
  - Cycle 2: `imem_req`=1, `imem_addr`=`RESET_VECTOR`.
- `imem_ack` is sampled in the same cycle as `imem_req`, so a zero-wait ack is allowed.
- `instr_valid` rises the cycle after the ack.
- PC updates the cycle after the ISSUE handshake, and the next `imem_req` is asserted that same cycle.
- Peak throughput is one instruction per 2 cycles.
- Resume: `run` in HALTED at cycle t → `imem_req` at t+1.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic [2:0] fetch_state_t` with IDLE, BOOT, FETCH, ISSUE, HALTED.
  - Shared default-width localparams.
- Sub-module: one `counter_loadable` instance, `u_pc`, with WIDTH=ADDR_WIDTH. The FSM, instruction register and halt flag are local.

## Test plan
- Boot: RESET_VECTOR=0x10, `run` pulse, ack and ready always high → fetch addresses 0x10, 0x11, 0x12 on alternate cycles; `instr_pc` matches each.
- Memory wait: ack delayed 3 cycles at addr 0x05 → `imem_req` and `imem_addr`=0x05 stable for 4 cycles; `instr` = `imem_rdata` at ack.
- Decode stall plus branch: `instr_ready` low for 2 cycles, then high with `branch_valid` and target 0xA0 → `instr` held; next fetch at 0xA0; `u_pc` never sees `count_up` and `load` together.
- Wrap: ADDR_WIDTH=8, PC=0xFF, no branch → next fetch at 0x00.
- Halt/resume: `halt_req` pulse during FETCH at 0x20 → instruction 0x20 issues, then `halted`=1 with PC=0x21; `run` → fetch at 0x21 the next cycle.
- Reset mid-fetch: `reset` while `imem_req`=1 → next cycle all outputs at reset values; state IDLE; no `instr_valid`.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the tau instruction-fetch
// sequencer.
//   fetch_state_t      - sequencer FSM states
//   DEFAULT_ADDR_WIDTH - default PC / instruction-memory address width
//   DEFAULT_DATA_WIDTH - default instruction width
package fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        FETCH,
        ISSUE,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/counter_loadable.sv
// counter_loadable: up/down counter with parallel load. The counter wraps
// modulo 2^WIDTH. When several controls are active, count_up wins, then
// count_down, then load.
//   clock, reset    - clock; synchronous active-high reset (value -> 0)
//   enable          - gates every update
//   count_up        - value <= value + 1
//   count_down      - value <= value - 1
//   load            - value <= load_value
//   load_value      - parallel load data
//   value           - current count
module counter_loadable #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             count_up,
    input  logic             count_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (enable) begin
            if (count_up) begin
                value <= value + 1'b1;
            end else if (count_down) begin
                value <= value - 1'b1;
            end else if (load) begin
                value <= load_value;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Boots the PC to a reset
// vector, fetches one instruction per memory handshake, holds it for decode,
// and then advances the PC or redirects it to a branch target.
//   clock, reset               - clock; synchronous active-high reset
//   run                        - start from IDLE or resume from HALTED
//   halt_req                   - halt at the next instruction boundary
//   imem_req, imem_addr        - fetch request / address (always the PC)
//   imem_ack, imem_rdata       - memory accept and read data, same cycle
//   instr_valid, instr         - registered instruction offered to decode
//   instr_pc                   - PC of instr
//   instr_ready                - decode consumes instr this cycle
//   branch_valid/branch_target - redirect, qualified by the issue handshake
//   halted                     - sequencer is in HALTED
//   pc                         - current program counter
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH            = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH            = DEFAULT_DATA_WIDTH,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt_req,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  halt_pending;
    logic                  handshake;
    logic                  count_up;
    logic                  load;
    logic [ADDR_WIDTH-1:0] load_value;

    assign handshake = (state == ISSUE) && instr_ready;

    // The counter prioritises count_up, so the two controls are kept
    // mutually exclusive here.
    assign count_up   = handshake && !branch_valid;
    assign load       = (state == BOOT) || (handshake && branch_valid);
    assign load_value = (state == BOOT) ? RESET_PC : branch_target;

    counter_loadable #(
        .WIDTH (ADDR_WIDTH)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .enable     (1'b1),
        .count_up   (count_up),
        .count_down (1'b0),
        .load       (load),
        .load_value (load_value),
        .value      (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = BOOT;
            BOOT:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = ISSUE;
            // A halt request in the handshake cycle itself still takes effect.
            ISSUE:   if (instr_ready) state_next = (halt_pending || halt_req) ? HALTED : FETCH;
            HALTED:  if (run) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Every handshake either enters HALTED (which clears the flag) or returns
    // to FETCH with no request pending, so the flag always clears there.
    always_ff @(posedge clock) begin
        if (reset) begin
            halt_pending <= 1'b0;
        end else if (handshake) begin
            halt_pending <= 1'b0;
        end else if (halt_req && (state == FETCH || state == ISSUE)) begin
            halt_pending <= 1'b1;
        end
    end

    // NOTE: the instruction register is a datapath register, but it is still
    // reset because instr and instr_pc have defined values out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (state == FETCH && imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    // Handshake outputs depend only on registered state.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALTED);

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(count_up && load));
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with RESET_VECTOR
// 0x10. Memory and decode are driven from one linear initial block; every
// acknowledged fetch pushes its expected instruction/PC onto a scoreboard,
// and the entry is popped when the DUT presents instr_valid.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        halted;
    logic [7:0]  pc;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    fetch_sequencer #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (16),
        .RESET_VECTOR (32'h10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halted        (halted),
        .pc            (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: each word encodes its own address.
    function automatic logic [15:0] mem(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},    32'(imem_req),    32'd0);
        check({tag, "_imem_addr"},   32'(imem_addr),   32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"},       32'(instr),       32'd0);
        check({tag, "_instr_pc"},    32'(instr_pc),    32'd0);
        check({tag, "_halted"},      32'(halted),      32'd0);
        check({tag, "_pc"},          32'(pc),          32'd0);
    endtask

    // Entered in FETCH. Holds ack low for wait_cycles, optionally pulsing
    // halt_req in the first fetch cycle, then acknowledges with mem(addr).
    task automatic do_fetch(input logic [7:0] addr, input int wait_cycles, input bit hreq);
        check("fetch_req",    32'(imem_req),  32'd1);
        check("fetch_addr",   32'(imem_addr), 32'(addr));
        check("fetch_halted", 32'(halted),    32'd0);
        for (int i = 0; i < wait_cycles; i++) begin
            imem_ack = 1'b0;
            halt_req = hreq && (i == 0);
            tick();
            halt_req = 1'b0;
            check("wait_req",  32'(imem_req),  32'd1);
            check("wait_addr", 32'(imem_addr), 32'(addr));
        end
        imem_ack   = 1'b1;
        imem_rdata = mem(addr);
        halt_req   = hreq && (wait_cycles == 0);
        sb.push_back('{instr: mem(addr), pc: addr});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        halt_req   = 1'b0;
    endtask

    // Entered in ISSUE. Stalls decode for stall cycles (with a bogus branch
    // that must be ignored), then completes the handshake.
    task automatic do_issue(input int stall, input bit br, input logic [7:0] tgt, input bit hreq);
        exp_t e;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_req",   32'(imem_req),    32'd0);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check("issue_instr",    32'(instr),    32'(e.instr));
        check("issue_instr_pc", 32'(instr_pc), 32'(e.pc));
        for (int i = 0; i < stall; i++) begin
            instr_ready   = 1'b0;
            branch_valid  = 1'b1;
            branch_target = 8'h77;
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", 32'(instr),       32'(e.instr));
            check("stall_pc",    32'(instr_pc),    32'(e.pc));
        end
        instr_ready   = 1'b1;
        branch_valid  = br;
        branch_target = tgt;
        halt_req      = hreq;
        tick();
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 8'h00;
        halt_req      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        imem_rdata = 16'h0; instr_ready = 1'b0; branch_valid = 1'b0;
        branch_target = 8'h00;
        tick();
        tick();
        check_reset_outputs("por");

        // IDLE: halt_req is ignored and nothing is fetched.
        reset    = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("idle_req",    32'(imem_req), 32'd0);
        check("idle_halted", 32'(halted),   32'd0);

        // Boot: run -> BOOT -> FETCH at the reset vector.
        run = 1'b1;
        tick();
        run = 1'b0;
        check("boot_req", 32'(imem_req), 32'd0);
        tick();
        do_fetch(8'h10, 0, 1'b0); do_issue(0, 1'b0, 8'h00, 1'b0);
        do_fetch(8'h11, 0, 1'b0); do_issue(0, 1'b0, 8'h00, 1'b0);
        do_fetch(8'h12, 0, 1'b0); do_issue(0, 1'b1, 8'h05, 1'b0);

        // Memory wait of 3 cycles at 0x05 (run during FETCH is ignored),
        // then a decode stall followed by a branch to 0xA0.
        run = 1'b1;
        do_fetch(8'h05, 3, 1'b0);
        run = 1'b0;
        do_issue(2, 1'b1, 8'hA0, 1'b0);
        do_fetch(8'hA0, 0, 1'b0); do_issue(0, 1'b1, 8'hFF, 1'b0);

        // Wrap: 0xFF + 1 -> 0x00.
        do_fetch(8'hFF, 0, 1'b0); do_issue(0, 1'b0, 8'h00, 1'b0);
        do_fetch(8'h00, 0, 1'b0); do_issue(0, 1'b1, 8'h20, 1'b0);

        // Halt requested during FETCH at 0x20: 0x20 still issues.
        do_fetch(8'h20, 1, 1'b1); do_issue(0, 1'b0, 8'h00, 1'b0);
        check("halt1_halted", 32'(halted),      32'd1);
        check("halt1_req",    32'(imem_req),    32'd0);
        check("halt1_valid",  32'(instr_valid), 32'd0);
        check("halt1_pc",     32'(pc),          32'h21);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("halt1_stay", 32'(halted), 32'd1);
        check("halt1_pc2",  32'(pc),     32'h21);

        // Resume: imem_req the cycle after run, at the current PC.
        run = 1'b1;
        tick();
        run = 1'b0;
        do_fetch(8'h21, 0, 1'b0);
        // Halt request in the same cycle as the issue handshake.
        do_issue(0, 1'b0, 8'h00, 1'b1);
        check("halt2_halted", 32'(halted), 32'd1);
        check("halt2_pc",     32'(pc),     32'h22);
        run = 1'b1;
        tick();
        run = 1'b0;
        do_fetch(8'h22, 0, 1'b0); do_issue(0, 1'b0, 8'h00, 1'b0);
        do_fetch(8'h23, 0, 1'b0); do_issue(0, 1'b0, 8'h00, 1'b0);

        // Reset mid-fetch at 0x24.
        check("pre_reset_req",  32'(imem_req),  32'd1);
        check("pre_reset_addr", 32'(imem_addr), 32'h24);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_fetch");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_req",   32'(imem_req),    32'd0);
            check("post_reset_valid", 32'(instr_valid), 32'd0);
        end

        // Reboot from IDLE returns to the reset vector.
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        do_fetch(8'h10, 2, 1'b0); do_issue(1, 1'b0, 8'h00, 1'b0);
        check("end_next_addr", 32'(imem_addr), 32'h11);
        check("sb_drained",    32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
